// File: rtl/concentrator_scan_arbiter_if.sv
// rtl/concentrator_scan_arbiter_if.sv - sensor, control and Avalon-ST byte-stream signals of the scan arbiter
interface concentrator_scan_arbiter_if #(
   parameter int SENSORS_NUMBER = 4,
   parameter int PACKET_VALUE   = 3
);
   logic                                  st;
   logic [SENSORS_NUMBER-1:0]             sens_req;
   logic [SENSORS_NUMBER*PACKET_VALUE*8-1:0] sens_data;
   logic [SENSORS_NUMBER-1:0]             sens_ack;
   logic                                  sink_ready;
   logic [7:0]                            avalon_st_data;
   logic                                  avalon_st_valid;
   logic                                  avalon_st_startofpacket;
   logic                                  avalon_st_endofpacket;
   logic                                  busy;
   logic                                  overrun;

   modport master (
      input  st, sens_req, sens_data, sink_ready,
      output sens_ack, avalon_st_data, avalon_st_valid, avalon_st_startofpacket,
             avalon_st_endofpacket, busy, overrun
   );

   modport slave (
      output st, sens_req, sens_data, sink_ready,
      input  sens_ack, avalon_st_data, avalon_st_valid, avalon_st_startofpacket,
             avalon_st_endofpacket, busy, overrun
   );
endinterface

// File: rtl/concentrator_scan_arbiter.sv
// rtl/concentrator_scan_arbiter.sv - round-robin scan arbiter framing each ready sensor into an Avalon-ST packet
// SCAN_TRAILER_EN adds a two-byte trailer packet (EE, packet count) at the end of every scan.
module concentrator_scan_arbiter #(
   parameter int SENSORS_NUMBER     = 4,
   parameter int LOG_SENSORS_NUMBER = 3,
   parameter int PACKET_VALUE       = 3
) (
   input logic clk,
   input logic rst,
   concentrator_scan_arbiter_if.master bus
);
   localparam int FW = PACKET_VALUE * 8;
   localparam int PW = LOG_SENSORS_NUMBER + 1;
   localparam logic [PW-1:0] N_P = PW'(SENSORS_NUMBER);

`ifdef SCAN_TRAILER_EN
   typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND, TRAIL} state_t;
   logic [7:0] pkts_q, pkts_d;
`else
   typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND} state_t;
`endif

   state_t                        state_q, state_d;
   logic [SENSORS_NUMBER-1:0]     pending_q, pending_d;
   logic [LOG_SENSORS_NUMBER-1:0] rr_q, rr_d;
   logic [LOG_SENSORS_NUMBER-1:0] grant_q, grant_d;
   logic [3:0]                    cnt_q, cnt_d;
   logic [FW-1:0]                 sreg_q, sreg_d;
   logic [7:0]                    data_q, data_d;
   logic                          valid_q, valid_d;
   logic                          sop_q, sop_d;
   logic                          eop_q, eop_d;
   logic                          busy_q, busy_d;
   logic                          overrun_q, overrun_d;
   logic [SENSORS_NUMBER-1:0]     ack_q, ack_d;

   logic [SENSORS_NUMBER-1:0]     rot;
   logic [PW-1:0]                 off, sum, nxt;
   logic                          found;
   logic [LOG_SENSORS_NUMBER-1:0] sel;

   // Rotate pending so bit 0 is rr_ptr; the first set bit is the offset to the grant.
   always_comb begin
      rot   = SENSORS_NUMBER'({pending_q, pending_q} >> rr_q);
      found = 1'b0;
      off   = '0;
      for (int k = 0; k < SENSORS_NUMBER; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = PW'(k);
         end
      end
      sum = {1'b0, rr_q} + off;
      if (sum >= N_P) sum = sum - N_P;
      sel = sum[LOG_SENSORS_NUMBER-1:0];
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      rr_d      = rr_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      ack_d     = '0;
      overrun_d = bus.st && (state_q != IDLE);
      nxt       = {1'b0, grant_q} + PW'(1);
      if (nxt >= N_P) nxt = '0;
`ifdef SCAN_TRAILER_EN
      pkts_d    = pkts_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.st) begin
               pending_d = bus.sens_req;
`ifdef SCAN_TRAILER_EN
               pkts_d = '0;
               if (bus.sens_req != '0) begin
                  state_d = ARB;
               end else begin
                  state_d = TRAIL;
                  valid_d = 1'b1;
                  data_d  = 8'hEE;
                  sop_d   = 1'b1;
                  eop_d   = 1'b0;
               end
`else
               if (bus.sens_req != '0) state_d = ARB;
`endif
            end
         end
         ARB: begin
            grant_d = sel;
            ack_d   = SENSORS_NUMBER'(1) << sel;
            state_d = LOAD;
         end
         LOAD: begin
            sreg_d    = FW'(bus.sens_data >> (int'(grant_q) * FW));
            pending_d = pending_q & ~ack_q;
            rr_d      = nxt[LOG_SENSORS_NUMBER-1:0];
            data_d    = {4'hA, 4'(grant_q)};
            valid_d   = 1'b1;
            sop_d     = 1'b1;
            eop_d     = 1'b0;
            cnt_d     = '0;
`ifdef SCAN_TRAILER_EN
            pkts_d    = pkts_q + 8'd1;
`endif
            state_d   = SEND;
         end
         SEND: begin
            if (valid_q && bus.sink_ready) begin
               if (eop_q) begin
                  valid_d = 1'b0;
                  sop_d   = 1'b0;
                  eop_d   = 1'b0;
                  if (pending_q != '0) begin
                     state_d = ARB;
                  end else begin
`ifdef SCAN_TRAILER_EN
                     state_d = TRAIL;
                     valid_d = 1'b1;
                     data_d  = 8'hEE;
                     sop_d   = 1'b1;
`else
                     state_d = IDLE;
`endif
                  end
               end else begin
                  data_d = sreg_q[FW-1 -: 8];
                  sreg_d = sreg_q << 8;
                  cnt_d  = cnt_q + 4'd1;
                  sop_d  = 1'b0;
                  eop_d  = (cnt_q + 4'd1) == 4'(PACKET_VALUE);
               end
            end
         end
`ifdef SCAN_TRAILER_EN
         TRAIL: begin
            if (valid_q && bus.sink_ready) begin
               if (eop_q) begin
                  valid_d = 1'b0;
                  eop_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  data_d = pkts_q;
                  sop_d  = 1'b0;
                  eop_d  = 1'b1;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rr_q      <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         sreg_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         ack_q     <= '0;
`ifdef SCAN_TRAILER_EN
         pkts_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_q      <= rr_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         sreg_q    <= sreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         ack_q     <= ack_d;
`ifdef SCAN_TRAILER_EN
         pkts_q    <= pkts_d;
`endif
      end
   end

   assign bus.sens_ack                = ack_q;
   assign bus.avalon_st_data          = data_q;
   assign bus.avalon_st_valid         = valid_q;
   assign bus.avalon_st_startofpacket = sop_q;
   assign bus.avalon_st_endofpacket   = eop_q;
   assign bus.busy                    = busy_q;
   assign bus.overrun                 = overrun_q;
endmodule

// File: tb/tb_concentrator_scan_arbiter.sv
// tb/tb_concentrator_scan_arbiter.sv - self-checking bench for concentrator_scan_arbiter (honours SCAN_TRAILER_EN)
module tb_concentrator_scan_arbiter;
   localparam int N  = 4;
   localparam int PV = 3;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
      logic [1:0] gap;
   } beat_t;

   typedef struct packed {
      logic [3:0]  req;
      logic [2:0]  n;
      logic [15:0] ord;
      logic        bp;
   } vec_t;

   logic  clk = 1'b0;
   logic  rst;
   int    checks = 0;
   int    errors = 0;
   bit    bp_mode = 1'b0;
   beat_t exp_q[$];
   logic [3:0] ack_exp[$];

   concentrator_scan_arbiter_if #(.SENSORS_NUMBER(N), .PACKET_VALUE(PV)) bus();

   concentrator_scan_arbiter #(
      .SENSORS_NUMBER(N), .LOG_SENSORS_NUMBER(3), .PACKET_VALUE(PV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input int g, input logic [23:0] f, input bit first);
      exp_q.push_back('{d: 8'hA0 | 8'(g), sop: 1'b1, eop: 1'b0, gap: first ? 2'd0 : 2'd2});
      for (int b = 0; b < PV; b++)
         exp_q.push_back('{d: f[23-8*b -: 8], sop: 1'b0, eop: (b == PV-1), gap: 2'd0});
      ack_exp.push_back(4'(1 << g));
   endtask

   task automatic push_trailer(input int n);
`ifdef SCAN_TRAILER_EN
      exp_q.push_back('{d: 8'hEE, sop: 1'b1, eop: 1'b0, gap: 2'd0});
      exp_q.push_back('{d: 8'(n), sop: 1'b0, eop: 1'b1, gap: 2'd0});
`else
      if (n < 0) exp_q.delete();
`endif
   endtask

   task automatic start_scan(input logic [3:0] req, input logic [95:0] data);
      @(posedge clk); #1;
      bus.sens_data = data;
      bus.sens_req  = req;
      bus.st        = 1'b1;
      @(posedge clk); #1;
      bus.st        = 1'b0;
      bus.sens_req  = 4'($urandom);
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while ((bus.busy || exp_q.size() != 0 || ack_exp.size() != 0) && cyc < 2000);
      chk(name, 32'({bus.busy, 8'(exp_q.size()), 8'(ack_exp.size())}), 32'd0);
   endtask

   task automatic wait_q_below(input int lim, input string name);
      int cyc = 0;
      while (exp_q.size() >= lim && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk(name, 32'(exp_q.size() < lim), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      logic [95:0] data;
      int g;
      data = {$urandom, $urandom, $urandom};
      for (int i = 0; i < int'(v.n); i++) begin
         g = int'(v.ord[15-4*i -: 4]);
         push_pkt(g, data[g*24 +: 24], i == 0);
      end
      push_trailer(int'(v.n));
      bp_mode = v.bp;
      start_scan(v.req, data);
      wait_done("scan_done");
      bp_mode = 1'b0;
   endtask

   initial begin
      bus.sink_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.sink_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Stream monitor: pops the scoreboard on every transfer and checks hold, gap and ack rules.
   initial begin
      logic       in_pkt;
      logic       hold;
      logic [9:0] held;
      int         gapc;
      beat_t      e;
      in_pkt = 1'b0; hold = 1'b0; held = '0; gapc = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_pkt = 1'b0; hold = 1'b0; gapc = 0;
         end else begin
            if (bus.sens_ack != '0) begin
               if (ack_exp.size() == 0) chk("ack_unexpected", 32'(bus.sens_ack), 32'd0);
               else chk("sens_ack", 32'(bus.sens_ack), 32'(ack_exp.pop_front()));
            end
            if (hold)
               chk("hold_stable", 32'({bus.avalon_st_valid, bus.avalon_st_data,
                   bus.avalon_st_startofpacket, bus.avalon_st_endofpacket}), 32'({1'b1, held}));
            if (in_pkt) chk("valid_in_packet", 32'(bus.avalon_st_valid), 32'd1);
            if (bus.avalon_st_valid && bus.sink_ready) begin
               if (exp_q.size() == 0) begin
                  chk("beat_unexpected", 32'({bus.avalon_st_valid, bus.avalon_st_data}), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", 32'({bus.avalon_st_data, bus.avalon_st_startofpacket,
                      bus.avalon_st_endofpacket}), 32'({e.d, e.sop, e.eop}));
                  if (e.gap != 2'd0) chk("packet_gap", 32'(gapc), 32'(e.gap));
               end
               in_pkt = !bus.avalon_st_endofpacket;
               gapc   = 0;
            end else if (!bus.avalon_st_valid) begin
               gapc++;
            end
            hold = bus.avalon_st_valid && !bus.sink_ready;
            held = {bus.avalon_st_data, bus.avalon_st_startofpacket, bus.avalon_st_endofpacket};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        vecs[9];
      logic [95:0] data;
      int          sz0;
      vecs[0] = '{req: 4'b0101, n: 3'd2, ord: 16'h0200, bp: 1'b0};
      vecs[1] = '{req: 4'b1111, n: 3'd4, ord: 16'h3012, bp: 1'b0};
      vecs[2] = '{req: 4'b0011, n: 3'd2, ord: 16'h0100, bp: 1'b1};
      vecs[3] = '{req: 4'b1000, n: 3'd1, ord: 16'h3000, bp: 1'b1};
      vecs[4] = '{req: 4'b1111, n: 3'd4, ord: 16'h0123, bp: 1'b1};
      vecs[5] = '{req: 4'b1001, n: 3'd2, ord: 16'h0300, bp: 1'b0};
      vecs[6] = '{req: 4'b0110, n: 3'd2, ord: 16'h1200, bp: 1'b0};
      vecs[7] = '{req: 4'b0000, n: 3'd0, ord: 16'h0000, bp: 1'b0};
      vecs[8] = '{req: 4'b0100, n: 3'd1, ord: 16'h2000, bp: 1'b1};

      rst = 1'b1;
      bus.st = 1'b0;
      bus.sens_req = '0;
      bus.sens_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({bus.avalon_st_valid, bus.avalon_st_startofpacket,
          bus.avalon_st_endofpacket, bus.avalon_st_data, bus.sens_ack, bus.busy, bus.overrun}), 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;

      // Single sensor 2 with known payload, checking first-packet latency.
      data = {$urandom, $urandom, $urandom};
      data[71:48] = 24'h123456;
      push_pkt(2, 24'h123456, 1'b1);
      push_trailer(1);
      @(posedge clk); #1;
      bus.sens_data = data;
      bus.sens_req  = 4'b0100;
      bus.st        = 1'b1;
      @(posedge clk); #1;
      bus.st        = 1'b0;
      bus.sens_req  = 4'($urandom);
      @(negedge clk);
      chk("lat_arb", 32'({bus.busy, bus.avalon_st_valid}), 32'b10);
      @(negedge clk);
      chk("lat_load", 32'(bus.avalon_st_valid), 32'd0);
      @(negedge clk);
      chk("lat_header", 32'({bus.avalon_st_valid, bus.avalon_st_startofpacket, bus.avalon_st_data}),
          32'({1'b1, 1'b1, 8'hA2}));
      wait_done("single_done");

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // st while busy: one overrun pulse, no re-snapshot.
      data = {$urandom, $urandom, $urandom};
      push_pkt(3, data[72 +: 24], 1'b1);
      push_pkt(0, data[0 +: 24], 1'b0);
      push_pkt(1, data[24 +: 24], 1'b0);
      push_pkt(2, data[48 +: 24], 1'b0);
      push_trailer(4);
      sz0 = exp_q.size();
      start_scan(4'hF, data);
      wait_q_below(sz0, "overrun_wait");
      @(posedge clk); #1;
      bus.st = 1'b1;
      bus.sens_req = 4'hF;
      @(posedge clk); #1;
      bus.st = 1'b0;
      @(negedge clk);
      chk("overrun_pulse", 32'(bus.overrun), 32'd1);
      @(negedge clk);
      chk("overrun_one_cycle", 32'(bus.overrun), 32'd0);
      wait_done("overrun_done");

      // Reset in the middle of a payload, then a fresh scan restarts from sensor 0.
      data = {$urandom, $urandom, $urandom};
      push_pkt(0, data[0 +: 24], 1'b1);
      push_trailer(1);
      sz0 = exp_q.size();
      start_scan(4'b0001, data);
      wait_q_below(sz0 - 1, "reset_wait");
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("reset_midpkt", 32'({bus.avalon_st_valid, bus.avalon_st_startofpacket,
          bus.avalon_st_endofpacket, bus.avalon_st_data, bus.sens_ack, bus.busy, bus.overrun}), 32'd0);
      exp_q.delete();
      ack_exp.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      run_vec('{req: 4'b1111, n: 3'd4, ord: 16'h0123, bp: 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
